pipelined_addsub: RTL
=====================

Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor for the ALU datapath.
- The carry chain is split into STAGES equal segments, one register stage per segment, giving one operation per cycle at a higher clock rate.
- A valid/ready handshake on both sides lets it sit between the operand-issue logic and result writeback, with full backpressure.
- Status flags (carry, signed overflow, zero) are produced alongside each result.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- STAGES, 4, pipeline depth and number of carry segments; 1 ≤ STAGES ≤ WIDTH, WIDTH % STAGES == 0 (elaboration error otherwise).
- SEG, WIDTH/STAGES, segment width (localparam, derived; not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add mode only).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry-out of MSB (subtract: 1 = no borrow).
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

Behaviour:
- Reset and clock: one clock and one reset. rst is asynchronous and active-high, and its polarity and synchronicity are fixed.
- Transfers: a beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Arithmetic:
  - Add: sum = a + b + cin, modulo 2^WIDTH.
  - Subtract: sum = a + ~b + 1, i.e. a − b. cin is ignored when sub=1.
  - cout is the carry out of bit WIDTH−1.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff = sub ? ~b : b.
  - zero = (sum == 0). zero is computed in the last stage from the full registered sum.
- Pipeline structure:
  - Stage k (0..STAGES−1) adds bits [k·SEG +: SEG] of a and b_eff with the carry registered from stage k−1. Stage 0 uses the effective carry-in (sub ? 1 : cin).
  - Upper, unprocessed operand slices travel down the pipeline in registers.
  - Lower result slices that are already complete are carried forward unchanged.
  - Each stage also carries a[MSB] and b_eff[MSB] for the overflow calculation.
- Latency: exactly STAGES cycles from acceptance to out_valid, with no backpressure. With STAGES=1, the result is registered once (1 cycle).
- Handshake:
  - Each stage k has valid_k and ready_k = !valid_k || ready_{k+1}. ready_STAGES = out_ready.
  - in_ready = ready_0. It is combinational from out_ready through the chain; no combinational path runs from in_valid to in_ready.
  - Stage k loads when ready_k. valid_k takes the upstream valid.
  - Throughput is 1 beat/cycle while out_ready=1.
  - Bubbles collapse: an empty stage accepts even when downstream is stalled.
  - While out_valid && !out_ready, sum/cout/ovf/zero hold stable.
  - A full pipeline holds exactly STAGES beats. in_ready=0 when all stages are valid and out_ready=0.
- Reset:
  - All valid_k clear immediately. out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 after reset.
  - Reset mid-operation discards all in-flight beats; none are emitted afterwards.
  - Datapath registers other than outputs need no reset.
- Simultaneous accept and consume in a full pipeline: allowed in the same cycle. The pipeline shifts by one and the occupancy is unchanged.
- Ordering: results leave strictly in acceptance order.
- Wrap-around:
  - a=2^WIDTH−1, b=1 gives sum=0, cout=1, zero=1.
  - Subtract of equal operands gives sum=0, cout=1, zero=1, ovf=0.

Decomposition:
- alu_pkg:
  - ALU_OP_ADD/ALU_OP_SUB encodings for the sub bit.
  - Default width constant (32).
  - A typedef for the flag bundle {cout, ovf, zero}.
- Sub-module addsub_segment: combinational SEG-bit adder (a_seg, b_seg, c_in → s_seg, c_out). It is instantiated once per stage via generate.
- All pipeline registers and handshake logic live in pipelined_addsub.

Test Plan:
- WIDTH=32, STAGES=4, out_ready=1. Add 0x0000_0005 + 0x0000_0003, cin=0 → after 4 cycles sum=0x0000_0008, cout=0, ovf=0, zero=0.
- Add 0xFFFF_FFFF + 0x0000_0001, cin=0 → sum=0, cout=1, zero=1 (carry crosses all 4 segments). Then 0x7FFF_FFFF + 1 → sum=0x8000_0000, ovf=1, cout=0.
- Subtract, sub=1, cin=1 (ignored): 0x0000_0003 − 0x0000_0005 → sum=0xFFFF_FFFE, cout=0. Then 0x8000_0000 − 1 → sum=0x7FFF_FFFF, ovf=1.
- Backpressure: stream 6 beats, hold out_ready=0 from cycle 2 → in_ready drops after 4 beats. Outputs stay stable while stalled. On release, all 6 results appear in order with no loss or duplication.
- Random valid/ready toggling, 1000 beats, checked against a reference model → exact in-order match. Repeat with STAGES=1, STAGES=8, and WIDTH=16/STAGES=2.
- Assert rst for 1 cycle with 3 beats in flight → out_valid=0 and flags=0 immediately. No stale beats emerge. The next accepted beat yields its correct result after 4 cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: operation encoding for the sub bit,
// default operand width and the status flag bundle.
package alu_pkg;

  typedef enum logic {
    ALU_OP_ADD = 1'b0,
    ALU_OP_SUB = 1'b1
  } alu_op_e;

  localparam int unsigned ALU_WIDTH = 32;

  typedef struct packed {
    logic cout;
    logic ovf;
    logic zero;
  } alu_flags_t;

endpackage

// File: rtl/addsub_segment.sv
// Combinational SEG-bit ripple segment used by each pipeline stage.
module addsub_segment #(
  parameter int unsigned SEG = 8
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic [SEG-1:0] s_seg,
  output logic           c_out
);

  assign {c_out, s_seg} = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG{1'b0}}, c_in};

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one carry segment per stage,
// valid/ready handshake with full backpressure, flags on the final stage.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = ALU_WIDTH,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SEG = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be >= 2 and a multiple of STAGES (1..WIDTH)");
  end

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign b_eff   = (sub == ALU_OP_SUB) ? ~b : b;
  assign cin_eff = (sub == ALU_OP_SUB) ? 1'b1 : cin;

  // Stage k keeps only the operand bits above its own segment, so the
  // operand registers shrink by SEG per stage while the result grows by SEG.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LW = (k + 1) * SEG;

    logic [SEG-1:0] sa, sb, ss;
    logic           ci, co, am, bm, v_in, v_q, rdy;
    logic [LW-1:0]  s_q, s_new;

    if (k == 0) begin : g_src
      assign sa    = a[SEG-1:0];
      assign sb    = b_eff[SEG-1:0];
      assign ci    = cin_eff;
      assign am    = a[WIDTH-1];
      assign bm    = b_eff[WIDTH-1];
      assign v_in  = in_valid;
      assign s_new = ss;
    end else begin : g_src
      assign sa    = g_stage[k-1].g_mid.a_q[SEG-1:0];
      assign sb    = g_stage[k-1].g_mid.b_q[SEG-1:0];
      assign ci    = g_stage[k-1].g_mid.c_q;
      assign am    = g_stage[k-1].g_mid.am_q;
      assign bm    = g_stage[k-1].g_mid.bm_q;
      assign v_in  = g_stage[k-1].v_q;
      assign s_new = {ss, g_stage[k-1].s_q};
    end

    addsub_segment #(.SEG(SEG)) u_seg (
      .a_seg (sa),
      .b_seg (sb),
      .c_in  (ci),
      .s_seg (ss),
      .c_out (co)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (rdy) begin
        v_q <= v_in;
      end
    end

    if (k < STAGES - 1) begin : g_mid
      localparam int unsigned UW = WIDTH - LW;

      logic [UW-1:0] a_q, b_q, up_a, up_b;
      logic          c_q, am_q, bm_q;

      if (k == 0) begin : g_up
        assign up_a = a[WIDTH-1:SEG];
        assign up_b = b_eff[WIDTH-1:SEG];
      end else begin : g_up
        assign up_a = g_stage[k-1].g_mid.a_q[UW+SEG-1:SEG];
        assign up_b = g_stage[k-1].g_mid.b_q[UW+SEG-1:SEG];
      end

      assign rdy = !v_q || g_stage[k+1].rdy;

      always_ff @(posedge clk) begin
        if (rdy && v_in) begin
          a_q  <= up_a;
          b_q  <= up_b;
          c_q  <= co;
          am_q <= am;
          bm_q <= bm;
          s_q  <= s_new;
        end
      end
    end else begin : g_last
      alu_flags_t flags_q;

      assign rdy = !v_q || out_ready;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s_q     <= '0;
          flags_q <= '0;
        end else if (rdy && v_in) begin
          s_q          <= s_new;
          flags_q.cout <= co;
          flags_q.ovf  <= (am == bm) && (s_new[WIDTH-1] != am);
          flags_q.zero <= (s_new == '0);
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign cout      = g_stage[STAGES-1].g_last.flags_q.cout;
  assign ovf       = g_stage[STAGES-1].g_last.flags_q.ovf;
  assign zero      = g_stage[STAGES-1].g_last.flags_q.zero;

endmodule
